// File: rtl/source_sequencer_pkg.sv
// rtl/source_sequencer_pkg.sv - shared widths, defaults and state encoding for the source sequencer
package source_sequencer_pkg;

    localparam int DEF_CLK_DIV    = 5;
    localparam int DEF_PER_W      = 8;
    localparam int DEF_AMP_W      = 15;
    localparam int DEF_LEN_W      = 8;
    localparam int DEF_RAMP_SHIFT = 4;

    // A period of zero tells SOURCE to generate noise instead of a pulse train.
    localparam int NOISE_PERIOD   = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_t;

endpackage

// File: rtl/source_sequencer_if.sv
// rtl/source_sequencer_if.sv - frame offer handshake between frame controller and sequencer
interface source_sequencer_if
    import source_sequencer_pkg::*;
#(
    parameter int PER_W = DEF_PER_W,
    parameter int AMP_W = DEF_AMP_W,
    parameter int LEN_W = DEF_LEN_W
);

    logic                    frame_valid;
    logic                    frame_ready;
    logic [PER_W-1:0]        frame_period;
    logic signed [AMP_W-1:0] frame_amp;
    logic [LEN_W-1:0]        frame_len;

    // Frame controller side: offers frames.
    modport master (
        output frame_valid,
        output frame_period,
        output frame_amp,
        output frame_len,
        input  frame_ready
    );

    // Sequencer side: accepts frames.
    modport slave (
        input  frame_valid,
        input  frame_period,
        input  frame_amp,
        input  frame_len,
        output frame_ready
    );

endinterface

// File: rtl/source_sequencer_strobe_gen.sv
// rtl/source_sequencer_strobe_gen.sv - free-running sample-rate divider producing the strobe pulse
module source_sequencer_strobe_gen
    import source_sequencer_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst_an,
    output logic tick,
    output logic strobe
);

    localparam int DIV_W = $clog2(CLK_DIV);

    logic [DIV_W-1:0] div;

    // tick marks the edge on which strobe is registered high; the sequencer updates on it.
    assign tick = (div == DIV_W'(CLK_DIV - 1));

    // Divider counts 0..CLK_DIV-1 and keeps running whatever the sequencer state.
    always_ff @(posedge clk) begin
        if (!rst_an) begin
            div    <= '0;
            strobe <= 1'b0;
        end else begin
            strobe <= tick;
            div    <= tick ? '0 : div + DIV_W'(1);
        end
    end

endmodule

// File: rtl/source_sequencer.sv
// rtl/source_sequencer.sv - frame sequencer driving SOURCE period/amplitude with per-sample ramping
module source_sequencer
    import source_sequencer_pkg::*;
#(
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int PER_W      = DEF_PER_W,
    parameter int AMP_W      = DEF_AMP_W,
    parameter int LEN_W      = DEF_LEN_W,
    parameter int RAMP_SHIFT = DEF_RAMP_SHIFT
) (
    input  logic                    clk,
    input  logic                    rst_an,
    source_sequencer_if.slave       frame,
    output logic [PER_W-1:0]        period,
    output logic signed [AMP_W-1:0] amplitude,
    output logic                    strobe,
    output logic                    busy,
    output logic                    underrun
);

    // Differences within +/-(2^RAMP_SHIFT - 1) would shift to a zero or -1 step, so they snap instead.
    localparam logic signed [AMP_W:0] SNAP_LIM = (AMP_W + 1)'(1 << RAMP_SHIFT);

    seq_state_t state;
    seq_state_t state_next;

    logic tick;

    logic                    ready_en;
    logic                    pend_full;
    logic [PER_W-1:0]        pend_period;
    logic signed [AMP_W-1:0] pend_amp;
    logic [LEN_W-1:0]        pend_len;

    logic signed [AMP_W-1:0] target;
    logic [LEN_W-1:0]        rem;

    logic accept;
    logic load_point;
    logic load_pend;
    logic load_byp;
    logic load;

    logic [PER_W-1:0]        src_period;
    logic signed [AMP_W-1:0] src_amp;
    logic [LEN_W-1:0]        src_len;

    logic [PER_W-1:0]        per_next;
    logic signed [AMP_W-1:0] tgt_next;
    logic [LEN_W-1:0]        rem_next;
    logic                    urun_next;
    logic signed [AMP_W:0]   diff;
    logic signed [AMP_W-1:0] step;
    logic signed [AMP_W-1:0] amp_next;

    source_sequencer_strobe_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_strobe_gen (
        .clk    (clk),
        .rst_an (rst_an),
        .tick   (tick),
        .strobe (strobe)
    );

    // ready_en holds frame_ready low through reset and for the release edge itself.
    always_ff @(posedge clk) begin
        if (!rst_an) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    assign frame.frame_ready = ready_en & ~pend_full;
    assign accept            = frame.frame_valid & frame.frame_ready;

    // A new frame can start only at a sample boundary where nothing is playing or the current frame ends.
    assign load_point = tick & ((state == ST_IDLE) | (rem == '0));
    assign load_pend  = load_point & pend_full;
    assign load_byp   = load_point & ~pend_full & accept;
    assign load       = load_pend | load_byp;

    // The pending slot takes priority; otherwise the frame on the bus goes straight to current.
    assign src_period = pend_full ? pend_period : frame.frame_period;
    assign src_amp    = pend_full ? pend_amp    : frame.frame_amp;
    assign src_len    = pend_full ? pend_len    : frame.frame_len;

    // Pending slot: capture an offered frame unless it bypasses, empty it when it is loaded.
    always_ff @(posedge clk) begin
        if (!rst_an) begin
            pend_full   <= 1'b0;
            pend_period <= '0;
            pend_amp    <= '0;
            pend_len    <= '0;
        end else if (accept && !load_byp) begin
            pend_full   <= 1'b1;
            pend_period <= frame.frame_period;
            pend_amp    <= frame.frame_amp;
            pend_len    <= frame.frame_len;
        end else if (load_pend) begin
            pend_full   <= 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_an) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: enter RUN on any load, fall back to IDLE when the last sample ends unrefilled.
    always_comb begin
        state_next = state;
        if (tick) begin
            if (load) begin
                state_next = ST_RUN;
            end else if ((state == ST_RUN) && (rem == '0)) begin
                state_next = ST_IDLE;
            end
        end
    end

    // Per-sample outputs: choose new period/target/remaining count, then ramp amplitude toward target.
    always_comb begin
        per_next  = period;
        tgt_next  = target;
        rem_next  = rem;
        urun_next = 1'b0;
        if (load) begin
            per_next = src_period;
            tgt_next = src_amp;
            rem_next = src_len - LEN_W'(1);
        end else if (state == ST_RUN) begin
            if (rem != '0) begin
                rem_next = rem - LEN_W'(1);
            end else begin
                urun_next = 1'b1;
                tgt_next  = '0;
            end
        end else begin
            tgt_next = '0;
        end

        diff = (AMP_W + 1)'(tgt_next) - (AMP_W + 1)'(amplitude);
        step = AMP_W'(diff >>> RAMP_SHIFT);
        if ((diff < SNAP_LIM) && (diff > -SNAP_LIM)) begin
            amp_next = tgt_next;
        end else begin
            amp_next = amplitude + step;
        end
    end

    // Sample datapath registers move only on the strobe edge; underrun is a single-clock pulse.
    always_ff @(posedge clk) begin
        if (!rst_an) begin
            period    <= PER_W'(NOISE_PERIOD);
            amplitude <= '0;
            target    <= '0;
            rem       <= '0;
            busy      <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            underrun <= tick & urun_next;
            if (tick) begin
                period    <= per_next;
                amplitude <= amp_next;
                target    <= tgt_next;
                rem       <= rem_next;
                busy      <= (state_next == ST_RUN);
            end
        end
    end

endmodule

// File: tb/tb_source_sequencer.sv
// tb/tb_source_sequencer.sv - directed self-checking bench for source_sequencer
module tb_source_sequencer;

    logic clk;
    logic rst_an;

    logic [7:0]         period;
    logic signed [14:0] amplitude;
    logic               strobe;
    logic               busy;
    logic               underrun;

    int compared;
    int mismatched;

    source_sequencer_if #(.PER_W(8), .AMP_W(15), .LEN_W(8)) frame_if ();

    source_sequencer #(
        .CLK_DIV    (5),
        .PER_W      (8),
        .AMP_W      (15),
        .LEN_W      (8),
        .RAMP_SHIFT (4)
    ) dut (
        .clk       (clk),
        .rst_an    (rst_an),
        .frame     (frame_if),
        .period    (period),
        .amplitude (amplitude),
        .strobe    (strobe),
        .busy      (busy),
        .underrun  (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_strobe(input string tag);
        int n;
        n = 0;
        do begin
            tick_clk();
            n++;
        end while (!strobe && n < 20);
        check(tag, strobe, 1);
    endtask

    task automatic do_reset();
        rst_an = 1'b0;
        repeat (2) tick_clk();
        rst_an = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] p, input logic signed [14:0] a, input logic [7:0] len);
        int n;
        frame_if.frame_valid  = 1'b1;
        frame_if.frame_period = p;
        frame_if.frame_amp    = a;
        frame_if.frame_len    = len;
        n = 0;
        while (!frame_if.frame_ready && n < 50) begin
            tick_clk();
            n++;
        end
        check("send_ready", frame_if.frame_ready, 1);
        tick_clk();
        frame_if.frame_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        compared   = 0;
        mismatched = 0;
        rst_an     = 1'b0;
        frame_if.frame_valid  = 1'b0;
        frame_if.frame_period = '0;
        frame_if.frame_amp    = '0;
        frame_if.frame_len    = '0;

        // Reset state
        repeat (3) tick_clk();
        check("rst_period", period, 0);
        check("rst_amp", amplitude, 0);
        check("rst_strobe", strobe, 0);
        check("rst_busy", busy, 0);
        check("rst_underrun", underrun, 0);
        check("rst_ready", frame_if.frame_ready, 0);

        // Strobe timing after release: clocks 5, 10
        rst_an = 1'b1;
        tick_clk();
        check("ready_after_release", frame_if.frame_ready, 1);
        check("strobe_clk1", strobe, 0);
        repeat (3) tick_clk();
        check("strobe_clk4", strobe, 0);
        tick_clk();
        check("strobe_clk5", strobe, 1);
        check("idle_busy", busy, 0);
        tick_clk();
        check("strobe_clk6", strobe, 0);
        repeat (4) tick_clk();
        check("strobe_clk10", strobe, 1);
        tick_clk();

        // Single frame p=50 a=15000 len=4
        send_frame(8'd50, 15'sd15000, 8'd4);
        wait_strobe("f1_s1");
        check("f1_s1_period", period, 50);
        check("f1_s1_amp", amplitude, 937);
        check("f1_s1_busy", busy, 1);
        wait_strobe("f1_s2");
        check("f1_s2_amp", amplitude, 1815);
        wait_strobe("f1_s3");
        check("f1_s3_amp", amplitude, 2639);
        wait_strobe("f1_s4");
        check("f1_s4_amp", amplitude, 3411);
        check("f1_s4_underrun", underrun, 0);
        wait_strobe("f1_s5");
        check("f1_s5_underrun", underrun, 1);
        check("f1_s5_busy", busy, 0);
        check("f1_s5_amp", amplitude, 3197);
        check("f1_s5_period_held", period, 50);
        tick_clk();
        check("f1_underrun_pulse", underrun, 0);

        // Decay to silence in IDLE
        cnt = 0;
        while (amplitude != 0 && cnt < 150) begin
            wait_strobe("decay_s");
            cnt++;
        end
        check("decay_amp", amplitude, 0);
        check("decay_busy", busy, 0);

        // Frame A queued then B; period switches on the 3rd strobe
        do_reset();
        send_frame(8'd50, 15'sd1000, 8'd2);
        frame_if.frame_valid  = 1'b1;
        frame_if.frame_period = 8'd0;
        frame_if.frame_amp    = 15'sd8000;
        frame_if.frame_len    = 8'd3;
        check("ab_ready_full", frame_if.frame_ready, 0);
        wait_strobe("ab_s1");
        check("ab_s1_period", period, 50);
        check("ab_s1_amp", amplitude, 62);
        check("ab_s1_ready", frame_if.frame_ready, 1);
        tick_clk();
        frame_if.frame_valid = 1'b0;
        check("ab_b_queued_ready", frame_if.frame_ready, 0);
        wait_strobe("ab_s2");
        check("ab_s2_period", period, 50);
        check("ab_s2_amp", amplitude, 120);
        wait_strobe("ab_s3");
        check("ab_s3_period", period, 0);
        check("ab_s3_amp", amplitude, 612);
        check("ab_s3_underrun", underrun, 0);
        check("ab_s3_busy", busy, 1);
        check("ab_s3_ready", frame_if.frame_ready, 1);

        // Snap to small target, then underrun on len=1
        do_reset();
        send_frame(8'd7, 15'sd10, 8'd1);
        wait_strobe("snap_s1");
        check("snap_amp", amplitude, 10);
        check("snap_period", period, 7);
        wait_strobe("snap_s2");
        check("snap_s2_underrun", underrun, 1);
        check("snap_s2_amp", amplitude, 0);

        // Bypass: offer lands on the strobe edge in IDLE with pending empty
        do_reset();
        wait_strobe("byp_s0");
        repeat (4) tick_clk();
        frame_if.frame_valid  = 1'b1;
        frame_if.frame_period = 8'd9;
        frame_if.frame_amp    = -15'sd16000;
        frame_if.frame_len    = 8'd1;
        tick_clk();
        frame_if.frame_valid = 1'b0;
        check("byp_strobe", strobe, 1);
        check("byp_period", period, 9);
        check("byp_amp", amplitude, -1000);
        check("byp_busy", busy, 1);
        check("byp_ready", frame_if.frame_ready, 1);

        // frame_len=0 plays 256 samples
        do_reset();
        send_frame(8'd3, 15'sd100, 8'd0);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            wait_strobe("len0_s");
            if (busy && !underrun) cnt++;
        end
        check("len0_busy_count", cnt, 256);
        wait_strobe("len0_s257");
        check("len0_underrun", underrun, 1);
        check("len0_busy_end", busy, 0);

        // Reset mid-RUN with pending full
        do_reset();
        send_frame(8'd20, 15'sd5000, 8'd10);
        wait_strobe("mid_s1");
        check("mid_busy", busy, 1);
        send_frame(8'd30, 15'sd500, 8'd5);
        check("mid_pending_full", frame_if.frame_ready, 0);
        wait_strobe("mid_s2");
        wait_strobe("mid_s3");
        rst_an = 1'b0;
        tick_clk();
        check("mid_rst_period", period, 0);
        check("mid_rst_amp", amplitude, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_strobe", strobe, 0);
        check("mid_rst_underrun", underrun, 0);
        check("mid_rst_ready", frame_if.frame_ready, 0);
        rst_an = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick_clk();
            if (busy || underrun || period != 0) cnt++;
        end
        check("mid_no_activity", cnt, 0);
        check("mid_ready_after", frame_if.frame_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
